// File: rtl/march_element_engine_pkg.sv
// Shared encodings for the march element engine: op fields, command bits and FSM states.
package march_element_engine_pkg;

    typedef enum logic [1:0] {
        MEE_IDLE  = 2'd0,
        MEE_RUN   = 2'd1,
        MEE_DRAIN = 2'd2
    } mee_state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int CMD_WE_BIT = 0;
    localparam int CMD_RD_BIT = 1;

    function automatic logic op_is_write(input logic [1:0] op);
        return op[1] == OP_WR;
    endfunction

endpackage

// File: rtl/march_element_engine_addr_gen.sv
// Address counter for one march element; reports when the terminal address is reached.
module march_addr_gen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dir,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_q, addr_d;
    logic          dir_q, dir_d;

    always_comb begin
        addr_d = addr_q;
        dir_d  = dir_q;
        if (load) begin
            dir_d  = dir;
            addr_d = dir ? '1 : '0;
        end else if (step) begin
            addr_d = dir_q ? addr_q - ONE : addr_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            dir_q  <= dir_d;
        end
    end

    // Terminal detection by compare keeps the caller from ever stepping past the end.
    assign last = dir_q ? (addr_q == '0) : (addr_q == '1);
    assign addr = addr_q;

endmodule

// File: rtl/march_element_engine.sv
// Runs one march element over the auxiliary memory and checks read data with a one-stage compare pipeline.
module march_element_engine
    import march_element_engine_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int CW     = 4,
    parameter int MAXOPS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                elem_dir,
    input  logic [1:0]          elem_nops,
    input  logic [2*MAXOPS-1:0] elem_ops,
    input  logic [DW-1:0]       elem_bg,
    output logic [CW-1:0]       mem_cmd,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [AW-1:0]       fail_addr,
    output logic [DW-1:0]       fail_data,
    output logic [7:0]          fail_cnt
);

    function automatic logic [CW-1:0] op_cmd(input logic [1:0] op);
        logic [CW-1:0] c;
        c = '0;
        if (op_is_write(op)) c[CMD_WE_BIT] = 1'b1;
        else                 c[CMD_RD_BIT] = 1'b1;
        return c;
    endfunction

    function automatic logic [DW-1:0] op_data(input logic [1:0] op, input logic [DW-1:0] bg);
        return op[0] ? ~bg : bg;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    mee_state_e          state_q, state_d;
    logic [1:0]          op_q, op_d, nxt_op, issue_op;
    logic [1:0]          nops_q;
    logic [2*MAXOPS-1:0] ops_q;
    logic [DW-1:0]       bg_q, bg_sel;
    logic [CW-1:0]       cmd_q, cmd_d;
    logic [DW-1:0]       wdata_q, wdata_d, exp_q, exp_d;
    logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [AW-1:0]       faddr_q, faddr_d;
    logic [DW-1:0]       fdata_q, fdata_d;
    logic [7:0]          fcnt_q, fcnt_d;
    logic                accept, load, step, issue, last;
    logic                vld_p1;
    logic [AW-1:0]       addr_p1;
    logic [DW-1:0]       exp_p1;

    march_addr_gen #(.AW(AW)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .dir  (elem_dir),
        .step (step),
        .addr (mem_addr),
        .last (last)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        issue    = 1'b0;
        issue_op = ops_q[1:0];
        bg_sel   = bg_q;
        nxt_op   = op_q + 2'd1;
        case (state_q)
            MEE_IDLE: begin
                // A start coinciding with done is dropped; upstream re-issues it.
                if (start && !done_q) begin
                    accept   = 1'b1;
                    load     = 1'b1;
                    state_d  = MEE_RUN;
                    busy_d   = 1'b1;
                    op_d     = '0;
                    issue    = 1'b1;
                    issue_op = elem_ops[1:0];
                    bg_sel   = elem_bg;
                end
            end
            MEE_RUN: begin
                if (op_q == nops_q) begin
                    if (last) begin
                        state_d = MEE_DRAIN;
                    end else begin
                        step     = 1'b1;
                        op_d     = '0;
                        issue    = 1'b1;
                        issue_op = ops_q[1:0];
                    end
                end else begin
                    op_d     = nxt_op;
                    issue    = 1'b1;
                    issue_op = ops_q[{nxt_op, 1'b0} +: 2];
                end
            end
            MEE_DRAIN: begin
                state_d = MEE_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = MEE_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        cmd_d   = issue ? op_cmd(issue_op) : '0;
        exp_d   = op_data(issue_op, bg_sel);
        wdata_d = (issue && op_is_write(issue_op)) ? exp_d : '0;

        fail_d  = fail_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        fcnt_d  = fcnt_q;
        if (accept) begin
            fail_d  = 1'b0;
            faddr_d = '0;
            fdata_d = '0;
            fcnt_d  = '0;
        end else if (vld_p1 && (mem_rdata != exp_p1)) begin
            fail_d = 1'b1;
            fcnt_d = sat_inc(fcnt_q);
            if (!fail_q) begin
                faddr_d = addr_p1;
                fdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEE_IDLE;
            op_q    <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            fdata_q <= '0;
            fcnt_q  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            fcnt_q  <= fcnt_d;
            vld_p1  <= cmd_q[CMD_RD_BIT];
        end
    end

    // Stage p1: address and expected value of the read whose data returns this cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            nops_q <= elem_nops;
            ops_q  <= elem_ops;
            bg_q   <= elem_bg;
        end
        exp_q   <= exp_d;
        addr_p1 <= mem_addr;
        exp_p1  <= exp_q;
    end

    assign mem_cmd   = cmd_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;
    assign fail_cnt  = fcnt_q;

endmodule

// File: tb/tb_march_element_engine.sv
// Bench for march_element_engine: 256x8 memory model, element-level reference model and per-cycle compare.
module tb_march_element_engine;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] addr;
        logic [7:0] wd;
    } op_t;

    logic       clk = 1'b0;
    logic       rst, start, elem_dir;
    logic [1:0] elem_nops;
    logic [7:0] elem_ops, elem_bg;
    logic [3:0] mem_cmd;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, fail;
    logic [7:0] fail_addr, fail_data, fail_cnt;

    always #5 clk = ~clk;

    march_element_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .elem_dir  (elem_dir),
        .elem_nops (elem_nops),
        .elem_ops  (elem_ops),
        .elem_bg   (elem_bg),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .fail_cnt  (fail_cnt)
    );

    // Requests posted by the stimulus process
    int         arm_id = 0, kill_id = 0, init_id = 0, rs_id = 0;
    bit         idle_chk = 0, fin_req = 0;
    logic [7:0] init_val = 8'h00;
    logic [7:0] and_m [256];
    logic [7:0] or_m  [256];
    int         lit_cyc;
    logic       lit_fail;
    logic [7:0] lit_fa, lit_fd, lit_fc, lit_ma, lit_mv;

    // Owned by the compare process
    int         n_chk = 0, n_fail = 0, cyc = 0, fin_id = 0;
    bit         active = 0;
    op_t        eq [$];
    logic [7:0] rm [256];
    logic       ex_fail;
    logic [7:0] ex_fa, ex_fd, ex_fc;

    // Memory model: 1-cycle read latency, per-address stuck masks on read
    logic [7:0] mem [256];
    int         m_seen = 0;
    always @(posedge clk) begin
        if (init_id != m_seen) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val;
            m_seen <= init_id;
        end else begin
            if (mem_cmd[0]) mem[mem_addr] <= mem_wdata;
            if (mem_cmd[1]) mem_rdata <= (mem[mem_addr] & and_m[mem_addr]) | or_m[mem_addr];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin : cmp
        int arm_seen, kill_seen, init_seen, rs_seen, cnt;
        logic [7:0] a, d, rd;
        logic [1:0] op;
        op_t o;
        bit drain;
        arm_seen = 0; kill_seen = 0; init_seen = 0; rs_seen = 0; drain = 0;
        forever begin
            @(negedge clk);
            if (init_id != init_seen) begin
                for (int i = 0; i < 256; i++) rm[i] = init_val;
                init_seen = init_id;
            end
            if (kill_id != kill_seen) begin
                eq.delete();
                active = 0;
                kill_seen = kill_id;
            end
            if (arm_id != arm_seen) begin
                arm_seen = arm_id;
                eq.delete();
                cnt = 0; ex_fa = 8'h00; ex_fd = 8'h00;
                for (int k = 0; k < 256; k++) begin
                    a = elem_dir ? 8'(255 - k) : 8'(k);
                    for (int j = 0; j <= int'(elem_nops); j++) begin
                        op = elem_ops[2*j +: 2];
                        d  = op[0] ? ~elem_bg : elem_bg;
                        if (op[1]) begin
                            eq.push_back({4'b0001, a, d});
                            rm[a] = d;
                        end else begin
                            eq.push_back({4'b0010, a, 8'h00});
                            rd = (rm[a] & and_m[a]) | or_m[a];
                            if (rd !== d) begin
                                if (cnt == 0) begin ex_fa = a; ex_fd = rd; end
                                cnt++;
                            end
                        end
                    end
                end
                ex_fail = (cnt > 0);
                ex_fc   = (cnt > 255) ? 8'd255 : 8'(cnt);
                active = 1; cyc = 0; drain = 0;
            end else if (rs_id != rs_seen) begin
                rs_seen = rs_id;
                check("rst_cmd", mem_cmd, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_wdata", mem_wdata, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_fail", fail, 0);
                check("rst_fail_addr", fail_addr, 0);
                check("rst_fail_data", fail_data, 0);
                check("rst_fail_cnt", fail_cnt, 0);
            end else if (active) begin
                cyc++;
                if (eq.size() > 0) begin
                    o = eq.pop_front();
                    check("op_cmd", mem_cmd, o.cmd);
                    check("op_addr", mem_addr, o.addr);
                    check("op_wdata", mem_wdata, o.wd);
                    check("op_busy", busy, 1);
                    check("op_done", done, 0);
                end else if (!drain) begin
                    drain = 1;
                    check("drain_cmd", mem_cmd, 0);
                    check("drain_busy", busy, 1);
                    check("drain_done", done, 0);
                end else begin
                    check("done", done, 1);
                    check("done_busy", busy, 0);
                    check("fail", fail, ex_fail);
                    check("fail_addr", fail_addr, ex_fa);
                    check("fail_data", fail_data, ex_fd);
                    check("fail_cnt", fail_cnt, ex_fc);
                    check("lit_cycles", cyc, lit_cyc);
                    check("lit_model_cnt", ex_fc, lit_fc);
                    check("lit_fail", fail, lit_fail);
                    check("lit_fail_addr", fail_addr, lit_fa);
                    check("lit_fail_data", fail_data, lit_fd);
                    check("lit_fail_cnt", fail_cnt, lit_fc);
                    check("lit_mem", mem[lit_ma], lit_mv);
                    active = 0;
                    fin_id = arm_seen;
                end
            end else if (idle_chk) begin
                check("idle_cmd", mem_cmd, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
            end
            if (fin_req) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    task automatic init_mem(input logic [7:0] v);
        init_val = v;
        init_id++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_masks();
        for (int i = 0; i < 256; i++) begin and_m[i] = 8'hFF; or_m[i] = 8'h00; end
    endtask

    task automatic run_elem(input logic dir, input logic [1:0] nops, input logic [7:0] ops, bg,
                            input int cyc_exp, input logic f, input logic [7:0] fa, fd, fc, ma, mv,
                            input bit poke);
        lit_cyc = cyc_exp; lit_fail = f; lit_fa = fa; lit_fd = fd; lit_fc = fc; lit_ma = ma; lit_mv = mv;
        @(posedge clk); #1;
        elem_dir = dir; elem_nops = nops; elem_ops = ops; elem_bg = bg;
        start = 1'b1;
        arm_id++;
        for (int c = 0; c < 4000 && fin_id != arm_id; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            elem_dir = ~dir; elem_ops = ~ops; elem_bg = ~bg; elem_nops = ~nops;
            if (poke && (c == 50 || done)) start = 1'b1;
        end
        start = 1'b0;
        if (fin_id != arm_id) begin
            $display("FAIL element_timeout: got no completion expected done within 4000 cycles");
            $fatal(1);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin : stim
        clear_masks();
        rst = 1'b1; start = 1'b0; elem_dir = 1'b0; elem_nops = 2'd0; elem_ops = 8'h00; elem_bg = 8'h00;
        repeat (2) @(posedge clk);
        #1 rs_id++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_chk = 1;
        init_mem(8'h00);

        // up(w0), bg 55
        run_elem(1'b0, 2'd0, 8'h02, 8'h55, 258, 1'b0, 8'h00, 8'h00, 8'h00, 8'h80, 8'h55, 0);
        // down(r0,w1)
        run_elem(1'b1, 2'd1, 8'h0C, 8'h55, 514, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 0);

        // stuck bit 0 at 3C
        init_mem(8'h55);
        and_m[8'h3C] = 8'hFE;
        run_elem(1'b1, 2'd1, 8'h0C, 8'h55, 514, 1'b1, 8'h3C, 8'h54, 8'h01, 8'h3C, 8'hAA, 0);
        clear_masks();

        // two faulty addresses under up(r0)
        init_mem(8'h00);
        or_m[8'h10] = 8'h01;
        or_m[8'h20] = 8'h01;
        run_elem(1'b0, 2'd0, 8'h00, 8'h00, 258, 1'b1, 8'h10, 8'h01, 8'h02, 8'h10, 8'h00, 0);

        // every read wrong, 768 mismatches: count saturates
        for (int i = 0; i < 256; i++) or_m[i] = 8'h80;
        run_elem(1'b0, 2'd2, 8'h00, 8'h00, 770, 1'b1, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h00, 0);
        clear_masks();

        // abort down(r0,w1) during op 100 with rst
        init_mem(8'h55);
        @(posedge clk); #1;
        elem_dir = 1'b1; elem_nops = 2'd1; elem_ops = 8'h0C; elem_bg = 8'h55;
        start = 1'b1;
        arm_id++;
        repeat (100) begin @(posedge clk); #1; start = 1'b0; end
        idle_chk = 0;
        kill_id++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rs_id++;
        @(posedge clk); #1;
        idle_chk = 1;

        // clean rerun, with start pulses while busy and in the done cycle
        init_mem(8'h55);
        run_elem(1'b1, 2'd1, 8'h0C, 8'h55, 514, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 1);

        repeat (4) @(posedge clk);
        fin_req = 1;
        repeat (5) @(posedge clk);
        $display("FAIL summary: got no summary line expected one");
        $fatal(1);
    end

endmodule
